systolic_nxn: RTL and testbench
===============================

# systolic_nxn

Parametrised N×N output-stationary systolic matrix multiplier with its own bus-mapped operand buffers, control/status registers and result readout. It replaces the fixed 2×2 array-plus-iobuf arrangement in the accelerator subsystem and sits behind the existing 16-bit ibus. Over a configurable depth K it computes C = A(N×K) · B(K×N) in signed Q(16−FRAC).FRAC arithmetic. It adds saturation reporting per PE, an accumulate mode, busy/done status and a done interrupt.

## Interface
- N, 4, array dimension (rows = cols), legal 2..4
- MAXK, 16, operand buffer depth; power of two, 4..64
- DW, 16, data width; fixed at 16 for this generation
- FRAC, 8, fraction bits; product is arithmetically shifted right by FRAC before accumulation
- clk  in  1  sole clock; everything is clocked on the rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- ren  in  1  bus read strobe
- ibus_radr  in  16  read address
- ibus_rdata  out  16  read data; registered; reset 0
- wen  in  1  bus write strobe
- ibus_wadr  in  16  write address
- ibus_wdata  in  16  write data
- done_irq  out  1  one-cycle pulse when a run completes; reset 0

## Operation
- Address map, word addressed:
  - 0x0000 CTRL (W)
    - bit0 start, self-clearing
    - bit1 acc: 1 keeps the accumulators, 0 zeroes them at start
    - bits[14:8] K
  - 0x0001 STATUS (R): bit0 busy, bit1 done, bit2 any_sat.
  - 0x0002 SATMASK (R): bit i·N+j is the sticky sat flag of PE(i,j).
  - 0x1000 + i·MAXK + k: A[i][k] (R/W).
  - 0x2000 + k·N + j: B[k][j] (R/W).
  - 0x3000 + i·N + j: C[i][j] (R).
  - All other addresses read 0. Writes to them are ignored.
- FSM: IDLE → RUN → DONE → IDLE.
  - IDLE → RUN on a CTRL write with start=1 and 1 ≤ K ≤ MAXK.
  - K = 0 or K > MAXK: go straight to DONE with no computation.
  - At start, clear done and all sat flags. Zero the accumulators if acc = 0.
- RUN uses step counter t = 0 .. K+2N−2.
  - Row i injects A[i][t−i] with valid=1 when 0 ≤ t−i < K; otherwise 0 with valid=0.
  - Column j injects B[t−j][j] under the same rule.
  - Each PE registers a/valid rightward and b/valid downward.
  - Each PE multiplies-accumulates only when both valids are 1.
- PE arithmetic:
  - p = (a·b signed 32-bit) >>> FRAC.
  - s = acc + p computed at 33 bits, then clamped to [−32768, 32767].
  - Set the sticky sat flag if the clamp occurred.
- DONE lasts one cycle: set done, pulse done_irq, return to IDLE.
- Bus rules while busy:
  - A/B writes are ignored.
  - A CTRL write with start=1 is ignored.
  - C reads return 0.
  - STATUS and SATMASK are always readable.
- rst:
  - FSM returns to IDLE; accumulators, flags, done, ibus_rdata and done_irq go to 0.
  - A/B buffer contents are unspecified after rst.

## Timing
- Read latency: ibus_rdata is valid the cycle after ren. It holds its value until the next ren.
- Buffers are synchronous-read RAMs. One read cycle precedes the first injection.
- Start write in cycle S: busy = 1 from S+1 through S+K+2N inclusive (K+2N cycles).
- In cycle S+K+2N+1, done = 1, done_irq = 1 and busy = 0.
- For K = 0 or K > MAXK: busy stays 0, and done/done_irq are asserted in cycle S+1.
- Simultaneous ren and wen to the same address: the read returns the old value.
- A new start is accepted in the cycle after done_irq.

## Structure
- systolic_pkg holds:
  - address region bases
  - CTRL/STATUS bit positions
  - FSM state enum
  - the saturating-add function
- One sub-module, systolic_pe: registered a/b/valid pass-through, MAC, accumulator, sat flag, clear input. The top instantiates N×N PEs in a generate loop.
- A buffer: N banks of MAXK words each. B buffer: N banks of MAXK words each. Per-bank reads give one word per row/column per cycle.

## Test plan
- Identity: A = diag 0x0100 (1.0), B[k][j] = (k·4+j)<<8, K=4, N=4 → C[i][j] = (i·4+j)<<8, busy exactly 12 cycles, one done_irq.
- Accumulate: repeat the identity run with acc=1 → every C doubles. Run again with acc=0 → C is back to single values.
- Saturation:
  - A = B = 0x7F00, K = 2 → all C = 0x7FFF, SATMASK = 0xFFFF, STATUS = 0x0006.
  - With negated A → all C = 0x8000.
- Bad K: K=0, then K=17 → done in cycle S+1, busy never set, C unchanged.
- Busy protection: during a run, write A/B/CTRL and read C → results match an undisturbed run, and the C reads return 0.
- Reset mid-run: assert rst at step t=3 → STATUS = 0, all C = 0, no done_irq. A following clean run matches expected values.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared definitions for the N x N systolic multiplier.
//   - bus address region bases and register addresses
//   - CTRL / STATUS bit positions
//   - FSM state encoding
//   - sat_add(): 33-bit accumulate with clamp to signed 16-bit
package systolic_pkg;

   localparam logic [15:0] ADR_CTRL    = 16'h0000;
   localparam logic [15:0] ADR_STATUS  = 16'h0001;
   localparam logic [15:0] ADR_SATMASK = 16'h0002;
   localparam logic [15:0] A_BASE      = 16'h1000;
   localparam logic [15:0] B_BASE      = 16'h2000;
   localparam logic [15:0] C_BASE      = 16'h3000;

   localparam int CTRL_START = 0;
   localparam int CTRL_ACC   = 1;
   localparam int CTRL_K_LSB = 8;
   localparam int CTRL_K_MSB = 14;

   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;
   localparam int ST_SAT  = 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic        sat;
      logic [15:0] val;
   } sat_res_t;

   localparam logic signed [32:0] SAT_MAX = 33'sd32767;
   localparam logic signed [32:0] SAT_MIN = -33'sd32768;

   // acc + p evaluated at 33 bits so the sum itself can never wrap.
   function automatic sat_res_t sat_add(input logic [15:0] acc, input logic [31:0] p);
      logic signed [32:0] s;
      sat_res_t           r;
      s = {{17{acc[15]}}, acc} + {p[31], p};
      if (s > SAT_MAX) begin
         r.sat = 1'b1;
         r.val = 16'h7FFF;
      end else if (s < SAT_MIN) begin
         r.sat = 1'b1;
         r.val = 16'h8000;
      end else begin
         r.sat = 1'b0;
         r.val = s[15:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one output-stationary processing element.
//   clk, rst          clock, synchronous active-high reset
//   clr_acc, clr_sat  zero the accumulator / sticky sat flag (start of run)
//   a_in, a_vld_in    operand from the left, forwarded registered to a_out
//   b_in, b_vld_in    operand from above, forwarded registered to b_out
//   acc               accumulated result (Q format, saturating)
//   sat               sticky: set when any accumulate clamped
module systolic_pe
   import systolic_pkg::*;
#(
   parameter int FRAC = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_acc,
   input  logic        clr_sat,
   input  logic [15:0] a_in,
   input  logic        a_vld_in,
   input  logic [15:0] b_in,
   input  logic        b_vld_in,
   output logic [15:0] a_out,
   output logic        a_vld_out,
   output logic [15:0] b_out,
   output logic        b_vld_out,
   output logic [15:0] acc,
   output logic        sat
);

   logic signed [31:0] prod;
   logic signed [31:0] prod_sh;
   sat_res_t           sum;
   logic               mac_en;

   always_comb begin
      prod    = 32'($signed(a_in)) * 32'($signed(b_in));
      prod_sh = prod >>> FRAC;
      sum     = sat_add(acc, prod_sh);
      mac_en  = a_vld_in && b_vld_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_out     <= '0;
         a_vld_out <= 1'b0;
         b_out     <= '0;
         b_vld_out <= 1'b0;
         acc       <= '0;
         sat       <= 1'b0;
      end else begin
         a_out     <= a_in;
         a_vld_out <= a_vld_in;
         b_out     <= b_in;
         b_vld_out <= b_vld_in;
         // clears only happen while the array is drained, so they never race a MAC
         if (clr_acc)
            acc <= '0;
         else if (mac_en)
            acc <= sum.val;
         if (clr_sat)
            sat <= 1'b0;
         else if (mac_en && sum.sat)
            sat <= 1'b1;
      end
   end

endmodule

// File: rtl/systolic_nxn.sv
// systolic_nxn: N x N output-stationary systolic multiplier, C = A(NxK) * B(KxN),
// behind a 16-bit word-addressed bus.
//   clk, rst              clock, synchronous active-high reset
//   ren, ibus_radr        read strobe / address; ibus_rdata registered, held until next ren
//   wen, ibus_wadr/wdata  write strobe / address / data
//   done_irq              one-cycle pulse when a run (or rejected start) completes
// Map: CTRL 0x0000, STATUS 0x0001, SATMASK 0x0002, A 0x1000+i*MAXK+k,
//      B 0x2000+k*N+j, C 0x3000+i*N+j; everything else reads 0.
module systolic_nxn
   import systolic_pkg::*;
#(
   parameter int N    = 4,
   parameter int MAXK = 16,
   parameter int DW   = 16,
   parameter int FRAC = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ren,
   input  logic [15:0] ibus_radr,
   output logic [15:0] ibus_rdata,
   input  logic        wen,
   input  logic [15:0] ibus_wadr,
   input  logic [15:0] ibus_wdata,
   output logic        done_irq
);

   localparam int AW = $clog2(MAXK);
   localparam int CW = 8;   // holds K + 2N - 1 for the largest legal K and N

   state_t        state, state_n;
   logic [CW-1:0] cnt;
   logic [6:0]    k_reg, k_new;
   logic          done_r, busy, any_sat;
   logic          start_req, k_ok, clr_acc, clr_sat;

   // operand buffers: A bank = row i, B bank = column j, both indexed by k
   logic [DW-1:0] a_mem [N][MAXK];
   logic [DW-1:0] b_mem [N][MAXK];

   logic [CW-1:0]         rel [N];
   logic [N-1:0]          inj_v, inj_vq;
   logic [N-1:0][DW-1:0]  a_inj, b_inj;

   logic [N-1:0][N:0][DW-1:0] a_h;
   logic [N-1:0][N:0]         av_h;
   logic [N:0][N-1:0][DW-1:0] b_v;
   logic [N:0][N-1:0]         bv_v;
   logic [N-1:0][N-1:0][DW-1:0] c_acc;
   logic [N*N-1:0]            sat_vec;
   logic [N-1:0]              unused_a;
   logic                      unused_b;
   logic [15:0]               rd_mux;

   assign busy      = (state == S_RUN);
   assign any_sat   = |sat_vec;
   assign k_new     = ibus_wdata[CTRL_K_MSB:CTRL_K_LSB];
   assign start_req = wen && (ibus_wadr == ADR_CTRL) && ibus_wdata[CTRL_START];
   assign k_ok      = (k_new != 7'd0) && (CW'(k_new) <= CW'(MAXK));

   // ---------------- control FSM ----------------
   always_comb begin
      state_n = state;
      clr_acc = 1'b0;
      clr_sat = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_req) begin
               if (k_ok) begin
                  state_n = S_RUN;
                  clr_sat = 1'b1;
                  clr_acc = !ibus_wdata[CTRL_ACC];
               end else begin
                  state_n = S_DONE;
               end
            end
         end
         // cnt 0 is the RAM read for step 0; last step K+2N-2 is injected at cnt K+2N-1
         S_RUN:   if (cnt == CW'(k_reg) + CW'(2*N - 1)) state_n = S_DONE;
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         k_reg    <= '0;
         done_r   <= 1'b0;
         done_irq <= 1'b0;
      end else begin
         state    <= state_n;
         done_irq <= (state_n == S_DONE);
         cnt      <= busy ? cnt + 1'b1 : '0;
         if (clr_sat)
            k_reg <= k_new;
         if (state_n == S_DONE)
            done_r <= 1'b1;
         else if (clr_sat)
            done_r <= 1'b0;
      end
   end

   // ---------------- operand buffers ----------------
   always_ff @(posedge clk) begin
      if (wen && !busy) begin
         for (int i = 0; i < N; i++) begin
            for (int k = 0; k < MAXK; k++) begin
               if (ibus_wadr == A_BASE + 16'(i*MAXK + k)) a_mem[i][k] <= ibus_wdata;
               if (ibus_wadr == B_BASE + 16'(k*N + i))    b_mem[i][k] <= ibus_wdata;
            end
         end
      end
   end

   // Skewed injection: row/column i is delayed by i steps; the same rule
   // gates both A row i and B column i, so one valid vector serves both edges.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         rel[i]   = cnt - CW'(i);
         inj_v[i] = busy && (cnt >= CW'(i)) && (rel[i] < CW'(k_reg));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_inj  <= '0;
         b_inj  <= '0;
         inj_vq <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            inj_vq[i] <= inj_v[i];
            a_inj[i]  <= inj_v[i] ? a_mem[i][rel[i][AW-1:0]] : '0;
            b_inj[i]  <= inj_v[i] ? b_mem[i][rel[i][AW-1:0]] : '0;
         end
      end
   end

   // ---------------- PE array ----------------
   for (genvar gi = 0; gi < N; gi++) begin : g_edge
      assign a_h[gi][0]  = a_inj[gi];
      assign av_h[gi][0] = inj_vq[gi];
      assign b_v[0][gi]  = b_inj[gi];
      assign bv_v[0][gi] = inj_vq[gi];
      assign unused_a[gi] = ^{a_h[gi][N], av_h[gi][N]};
   end
   assign unused_b = ^{b_v[N], bv_v[N]};

   for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
         systolic_pe #(.FRAC(FRAC)) u_pe (
            .clk       (clk),
            .rst       (rst),
            .clr_acc   (clr_acc),
            .clr_sat   (clr_sat),
            .a_in      (a_h[gi][gj]),
            .a_vld_in  (av_h[gi][gj]),
            .b_in      (b_v[gi][gj]),
            .b_vld_in  (bv_v[gi][gj]),
            .a_out     (a_h[gi][gj+1]),
            .a_vld_out (av_h[gi][gj+1]),
            .b_out     (b_v[gi+1][gj]),
            .b_vld_out (bv_v[gi+1][gj]),
            .acc       (c_acc[gi][gj]),
            .sat       (sat_vec[gi*N+gj])
         );
      end
   end

   // ---------------- bus readout ----------------
   always_comb begin
      rd_mux = '0;
      if (ibus_radr == ADR_STATUS) begin
         rd_mux[ST_BUSY] = busy;
         rd_mux[ST_DONE] = done_r;
         rd_mux[ST_SAT]  = any_sat;
      end
      if (ibus_radr == ADR_SATMASK)
         rd_mux = 16'(sat_vec);
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < MAXK; k++) begin
            if (ibus_radr == A_BASE + 16'(i*MAXK + k)) rd_mux = a_mem[i][k];
            if (ibus_radr == B_BASE + 16'(k*N + i))    rd_mux = b_mem[i][k];
         end
         for (int j = 0; j < N; j++) begin
            // partial sums are not exposed while a run is in flight
            if (!busy && ibus_radr == C_BASE + 16'(i*N + j)) rd_mux = c_acc[i][j];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         ibus_rdata <= '0;
      else if (ren)
         ibus_rdata <= rd_mux;
   end

endmodule

// File: tb/tb_systolic_nxn.sv
// tb_systolic_nxn: directed scoreboard bench for systolic_nxn (N=4, MAXK=16).
// Stimulus pushes expected read data / expected done_irq cycles into queues;
// a negedge monitor pops and compares whenever read data or done_irq appears.
module tb_systolic_nxn;

   localparam int N    = 4;
   localparam int MAXK = 16;
   localparam logic [15:0] R_CTRL    = 16'h0000;
   localparam logic [15:0] R_STATUS  = 16'h0001;
   localparam logic [15:0] R_SATMASK = 16'h0002;

   logic        clk, rst, ren, wen, done_irq;
   logic [15:0] ibus_radr, ibus_rdata, ibus_wadr, ibus_wdata;

   systolic_nxn #(.N(N), .MAXK(MAXK), .DW(16), .FRAC(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .ren        (ren),
      .ibus_radr  (ibus_radr),
      .ibus_rdata (ibus_rdata),
      .wen        (wen),
      .ibus_wadr  (ibus_wadr),
      .ibus_wdata (ibus_wdata),
      .done_irq   (done_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] adr;
      logic [15:0] exp;
   } rd_exp_t;

   rd_exp_t sb[$];
   int      irq_q[$];
   int      checks = 0;
   int      failures = 0;
   int      cyc = 0;
   logic    rd_q = 1'b0;
   logic    final_req = 1'b0;

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      rd_q <= ren && !rst;
   end

   always @(negedge clk) begin : monitor
      int      c, f, x;
      rd_exp_t e;
      c = 0;
      f = 0;
      if (rd_q) begin
         c++;
         if (sb.size() == 0) begin
            f++;
            $display("FAIL rd_unexpected got=%h exp=none", ibus_rdata);
         end else begin
            e = sb.pop_front();
            if (ibus_rdata !== e.exp) begin
               f++;
               $display("FAIL rd adr=%h got=%h exp=%h", e.adr, ibus_rdata, e.exp);
            end
         end
      end
      if (done_irq === 1'b1) begin
         c++;
         if (irq_q.size() == 0) begin
            f++;
            $display("FAIL irq_unexpected got_cycle=%0d exp=none", cyc);
         end else begin
            x = irq_q.pop_front();
            if (cyc != x) begin
               f++;
               $display("FAIL irq_cycle got=%0d exp=%0d", cyc, x);
            end
         end
      end
      if (final_req) begin
         c += 2;
         if (sb.size() != 0) begin
            f++;
            $display("FAIL reads_outstanding got=%0d exp=0", sb.size());
         end
         if (irq_q.size() != 0) begin
            f++;
            $display("FAIL irq_missing got=%0d_pending exp=0", irq_q.size());
         end
      end
      checks   <= checks + c;
      failures <= failures + f;
   end

   // one bus cycle: drive at negedge, hold across the posedge
   task automatic op(input logic r, input logic [15:0] ra, input logic w,
                     input logic [15:0] wa, input logic [15:0] wd);
      ren = r; ibus_radr = ra; wen = w; ibus_wadr = wa; ibus_wdata = wd;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) op(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      op(1'b0, 16'h0, 1'b1, a, d);
   endtask

   task automatic rd(input logic [15:0] a, input logic [15:0] e);
      sb.push_back('{a, e});
      op(1'b1, a, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic start(input int k, input logic acc, output int s);
      logic [6:0] kk;
      kk = 7'(k);
      s  = cyc;
      wr(R_CTRL, {1'b0, kk, 6'b0, acc, 1'b1});
   endtask

   // 0: identity result, 1: doubled, 2: +sat, 3: -sat, else zero
   function automatic logic [15:0] c_exp(input int mode, input int i, input int j);
      case (mode)
         0:       return 16'((i*4 + j) << 8);
         1:       return 16'((i*4 + j) << 9);
         2:       return 16'h7FFF;
         3:       return 16'h8000;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic check_c(input int mode);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            rd(16'(32'h3000 + i*N + j), c_exp(mode, i, j));
   endtask

   task automatic load_identity();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 4; k++)
            wr(16'(32'h1000 + i*MAXK + k), (i == k) ? 16'h0100 : 16'h0000);
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < N; j++)
            wr(16'(32'h2000 + k*N + j), 16'((k*4 + j) << 8));
   endtask

   task automatic load_sat(input logic [15:0] av);
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 2; k++)
            wr(16'(32'h1000 + i*MAXK + k), av);
      for (int k = 0; k < 2; k++)
         for (int j = 0; j < N; j++)
            wr(16'(32'h2000 + k*N + j), 16'h7F00);
   endtask

   initial begin : stim
      int s;
      rst = 1'b1; ren = 1'b0; wen = 1'b0;
      ibus_radr = '0; ibus_wadr = '0; ibus_wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // reset state and unmapped addresses
      rd(R_STATUS, 16'h0000);
      rd(R_SATMASK, 16'h0000);
      rd(16'h3000, 16'h0000);
      rd(16'h300F, 16'h0000);
      wr(16'h0003, 16'hFFFF);
      rd(16'h0003, 16'h0000);
      rd(16'h4000, 16'h0000);

      // buffer load, readback, read-during-write returns old data
      load_identity();
      rd(16'h1022, 16'h0100);
      rd(16'h200D, 16'h0D00);
      rd(16'h1040, 16'h0000);
      sb.push_back('{16'h1000, 16'h0100});
      op(1'b1, 16'h1000, 1'b1, 16'h1000, 16'h1234);
      rd(16'h1000, 16'h1234);
      wr(16'h1000, 16'h0100);

      // identity run: busy exactly K+2N = 12 cycles, done in cycle S+13
      start(4, 1'b0, s);
      irq_q.push_back(s + 13);
      repeat (12) rd(R_STATUS, 16'h0001);
      rd(R_STATUS, 16'h0002);
      check_c(0);

      // accumulate doubles, then a clearing run restores single values
      start(4, 1'b1, s);
      irq_q.push_back(s + 13);
      idle(14);
      check_c(1);
      start(4, 1'b0, s);
      irq_q.push_back(s + 13);
      idle(14);
      check_c(0);

      // illegal K: done next cycle, never busy, C untouched
      start(0, 1'b0, s);
      irq_q.push_back(s + 1);
      rd(R_STATUS, 16'h0002);
      rd(R_STATUS, 16'h0002);
      start(17, 1'b0, s);
      irq_q.push_back(s + 1);
      rd(R_STATUS, 16'h0002);
      rd(R_STATUS, 16'h0002);
      check_c(0);

      // busy protection: writes and restart ignored, C reads 0 mid-run
      start(4, 1'b0, s);
      irq_q.push_back(s + 13);
      wr(16'h1000, 16'h7FFF);
      wr(16'h2000, 16'h7FFF);
      wr(R_CTRL, 16'h0201);
      idle(8);
      rd(16'h300F, 16'h0000);
      idle(1);
      check_c(0);
      rd(16'h1000, 16'h0100);
      rd(16'h2000, 16'h0000);

      // positive saturation
      load_sat(16'h7F00);
      start(2, 1'b0, s);
      irq_q.push_back(s + 11);
      idle(12);
      check_c(2);
      rd(R_SATMASK, 16'hFFFF);
      rd(R_STATUS, 16'h0006);

      // negative saturation
      load_sat(16'h8100);
      start(2, 1'b0, s);
      irq_q.push_back(s + 11);
      idle(12);
      check_c(3);
      rd(R_SATMASK, 16'hFFFF);

      // reset at step t=3: no done_irq, everything cleared
      load_identity();
      start(4, 1'b0, s);
      idle(3);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(20);
      rd(R_STATUS, 16'h0000);
      rd(R_SATMASK, 16'h0000);
      check_c(4);

      // clean run after reset
      load_identity();
      start(4, 1'b0, s);
      irq_q.push_back(s + 13);
      idle(14);
      check_c(0);
      rd(R_STATUS, 16'h0002);

      idle(3);
      @(posedge clk);
      final_req = 1'b1;
      @(posedge clk);
      final_req = 1'b0;
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
